fcla_nibble_sequencer: RTL and testbench
========================================

FCLA_NIBBLE_SEQUENCER -- requirements
Module: fcla_nibble_sequencer

Interface
REQ-001 Parameter: ADDER_LAT, default 2, clock edges from a nibble presented on add_a/add_b/add_cin to its registered result on add_s/add_cout.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 in_valid  input  1  operand request valid.
REQ-005 in_ready  output  1  sequencer can accept a request.
REQ-006 a, b  input  16 each  operands.
REQ-007 cin  input  1  carry into nibble 0.
REQ-008 op_sub  input  1  subtract request; used only with SUB_EN.
REQ-009 add_a, add_b  output  4 each  nibble operands to the registered 4-bit CLA stage.
REQ-010 add_cin  output  1  carry to the CLA stage.
REQ-011 add_s  input  4  registered sum from the CLA stage.
REQ-012 add_cout  input  1  registered carry from the CLA stage.
REQ-013 out_valid  output  1  result valid.
REQ-014 out_ready  input  1  consumer accepts the result.
REQ-015 sum  output  16  result.
REQ-016 cout  output  1  carry out of nibble 3.

Function
REQ-017 FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE: in_ready=1.
- Accept on in_valid&&in_ready: latch a, b, cin; go to ISSUE with nibble index 0.
REQ-018 Drive add_a/add_b/add_cin from registers only. Hold them stable from the edge a nibble is issued until the edge it is captured.
- Nibble 0: add_cin = latched cin.
- Nibble k>0: add_cin = add_cout captured for nibble k-1.
REQ-019 Per nibble:
- ISSUE lasts one cycle, then WAIT.
- WAIT counts ADDER_LAT cycles.
- On the edge ending the last WAIT cycle, capture add_s into sum[4k+3:4k] and add_cout.
- Each nibble therefore costs ADDER_LAT+1 cycles.
REQ-020 After nibble 3 is captured, go to DONE.
- out_valid=1; cout = nibble-3 carry.
- With ADDER_LAT=2, out_valid rises on the 12th edge after the accept edge.
REQ-021 DONE holds sum, cout and out_valid stable until out_valid&&out_ready, then returns to IDLE.
REQ-022 in_ready=0 in ISSUE, WAIT and DONE. No accept-and-complete in the same cycle; a new request is accepted at the earliest in the cycle after the DONE handshake.
REQ-023 in_valid, a, b, cin and op_sub changes while busy are ignored.
REQ-024 Arithmetic is modulo 2^16; cout is the true 17th bit.

Reset
REQ-025 On rst, outputs take these values immediately, regardless of clk:
- FSM = IDLE
- in_ready=1, out_valid=0
- sum=0, cout=0
- add_a=0, add_b=0, add_cin=0
- nibble index=0, wait counter=0
REQ-026 rst mid-operation abandons the operation: no out_valid for it, and a stale add_s is never captured after reset release.
REQ-027 The first request after reset release can be accepted on the first rising edge with rst low.

Configuration
REQ-028 Macro FCLA_SEQ_SUB_EN.
- Defined: when op_sub=1 at accept, the latched b is ~b and the nibble-0 carry is 1, so the result is a-b. cout=1 means no borrow.
- Undefined: op_sub is ignored and b and cin are latched unmodified.

Verification
REQ-029 ADDER_LAT=2, a=0x1234, b=0x4321, cin=0 -> sum=0x5555, cout=0; out_valid on the 12th edge after accept.
REQ-030 a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1; add_cin=1 observed for nibbles 1-3.
REQ-031 a=0x00FF, b=0x0F01, cin=1 with out_ready=0 for 5 cycles after out_valid -> sum=0x1001, cout=0 held stable; in_ready=0 until the handshake completes.
REQ-032 rst pulse during nibble 2 WAIT -> all outputs at reset values while rst is high; the next request a=0x0001, b=0x0001 -> sum=0x0002.
REQ-033 FCLA_SEQ_SUB_EN defined, op_sub=1, a=0x0005, b=0x0007 -> sum=0xFFFE, cout=0; a=0x0007, b=0x0005 -> sum=0x0002, cout=1.

Source files
------------

// File: rtl/fcla_nibble_sequencer.sv
// fcla_nibble_sequencer
// Sequences a 16-bit add (optionally subtract) through an external registered
// 4-bit CLA stage, one nibble at a time, LSB nibble first. The CLA stage has
// ADDER_LAT edges of latency. Each nibble takes one ISSUE cycle and then
// ADDER_LAT WAIT cycles. The result nibble and its carry are captured on the
// edge that ends the last WAIT cycle.
// Optional feature macro: FCLA_SEQ_SUB_EN. When it is defined, op_sub_i=1 at
// accept turns the request into a - b.
//
// state  | meaning
// S_IDLE | ready for a request (in_ready_o=1)
// S_ISSUE| nibble operands are on add_*_o, one cycle
// S_WAIT | counting down ADDER_LAT cycles for the CLA stage result
// S_DONE | result held on sum_o/cout_o with out_valid_o=1 until handshake

module fcla_nibble_sequencer #(
   parameter int ADDER_LAT = 2
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        in_valid_i,
   output logic        in_ready_o,
   input  logic [15:0] a_i,
   input  logic [15:0] b_i,
   input  logic        cin_i,
   input  logic        op_sub_i,
   output logic [3:0]  add_a_o,
   output logic [3:0]  add_b_o,
   output logic        add_cin_o,
   input  logic [3:0]  add_s_i,
   input  logic        add_cout_i,
   output logic        out_valid_o,
   input  logic        out_ready_i,
   output logic [15:0] sum_o,
   output logic        cout_o
);

   localparam int CW = (ADDER_LAT < 2) ? 1 : $clog2(ADDER_LAT + 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t        state_q;
   logic [15:0]   a_q;
   logic [15:0]   b_q;
   logic [1:0]    nib_q;
   logic [CW-1:0] cnt_q;
   logic [3:0]    add_a_q;
   logic [3:0]    add_b_q;
   logic          add_cin_q;
   logic [15:0]   sum_q;
   logic          cout_q;
   logic          in_ready_q;
   logic          out_valid_q;

   logic [15:0]   b_d;
   logic          cin_d;
   logic [1:0]    nib_nxt;

   assign nib_nxt = nib_q + 2'd1;

`ifdef FCLA_SEQ_SUB_EN
   // Subtraction is a + ~b + 1, so only the latched operand and carry change.
   always_comb begin
      b_d   = b_i;
      cin_d = cin_i;
      if (op_sub_i) begin
         b_d   = ~b_i;
         cin_d = 1'b1;
      end
   end
`else
   logic unused_op_sub;
   assign unused_op_sub = op_sub_i;

   // Without subtract support the request operands pass through unchanged.
   always_comb begin
      b_d   = b_i;
      cin_d = cin_i;
   end
`endif

   // Sequencer FSM. Every output comes straight from a register.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= S_IDLE;
         a_q         <= '0;
         b_q         <= '0;
         nib_q       <= '0;
         cnt_q       <= '0;
         add_a_q     <= '0;
         add_b_q     <= '0;
         add_cin_q   <= 1'b0;
         sum_q       <= '0;
         cout_q      <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (in_valid_i && in_ready_q) begin
                  a_q        <= a_i;
                  b_q        <= b_d;
                  add_a_q    <= a_i[3:0];
                  add_b_q    <= b_d[3:0];
                  add_cin_q  <= cin_d;
                  nib_q      <= 2'd0;
                  in_ready_q <= 1'b0;
                  state_q    <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               cnt_q   <= CW'(ADDER_LAT);
               state_q <= S_WAIT;
            end
            S_WAIT: begin
               if (cnt_q == CW'(1)) begin
                  cnt_q                      <= '0;
                  sum_q[{nib_q, 2'b00} +: 4] <= add_s_i;
                  if (nib_q == 2'd3) begin
                     cout_q      <= add_cout_i;
                     out_valid_q <= 1'b1;
                     state_q     <= S_DONE;
                  end else begin
                     // The next nibble goes out on the same edge that captures this one,
                     // so the ripple carry never sits in an extra register.
                     nib_q     <= nib_nxt;
                     add_a_q   <= a_q[{nib_nxt, 2'b00} +: 4];
                     add_b_q   <= b_q[{nib_nxt, 2'b00} +: 4];
                     add_cin_q <= add_cout_i;
                     state_q   <= S_ISSUE;
                  end
               end else begin
                  cnt_q <= cnt_q - CW'(1);
               end
            end
            S_DONE: begin
               if (out_ready_i) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state_q     <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign in_ready_o  = in_ready_q;
   assign out_valid_o = out_valid_q;
   assign add_a_o     = add_a_q;
   assign add_b_o     = add_b_q;
   assign add_cin_o   = add_cin_q;
   assign sum_o       = sum_q;
   assign cout_o      = cout_q;

endmodule

// File: tb/tb_fcla_nibble_sequencer.sv
// Bench for fcla_nibble_sequencer with ADDER_LAT=2. A two-stage registered
// 4-bit adder stands in for the CLA stage. The bench checks each result, the
// per-nibble operands, latency, hold and ready behaviour, and reset.
// It checks against fixed vectors and against a whole-word arithmetic model.

module tb_fcla_nibble_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] a, b;
   logic        cin, op_sub;
   logic [3:0]  add_a, add_b, add_s;
   logic        add_cin, add_cout;
   logic        out_valid, out_ready;
   logic [15:0] sum;
   logic        cout;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   fcla_nibble_sequencer #(.ADDER_LAT(2)) dut (
      .clk_i(clk), .rst_i(rst),
      .in_valid_i(in_valid), .in_ready_o(in_ready),
      .a_i(a), .b_i(b), .cin_i(cin), .op_sub_i(op_sub),
      .add_a_o(add_a), .add_b_o(add_b), .add_cin_o(add_cin),
      .add_s_i(add_s), .add_cout_i(add_cout),
      .out_valid_o(out_valid), .out_ready_i(out_ready),
      .sum_o(sum), .cout_o(cout)
   );

   // The stand-in CLA stage registers its result twice, so it has two edges of latency.
   logic [4:0] cla_p1;
   always @(posedge clk) begin
      cla_p1              <= {1'b0, add_a} + {1'b0, add_b} + {4'b0, add_cin};
      {add_cout, add_s}   <= cla_p1;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, " in_ready"},  {31'b0, in_ready},  32'd1);
      chk({tag, " out_valid"}, {31'b0, out_valid}, 32'd0);
      chk({tag, " sum"},       {16'b0, sum},       32'd0);
      chk({tag, " cout"},      {31'b0, cout},      32'd0);
      chk({tag, " add_a"},     {28'b0, add_a},     32'd0);
      chk({tag, " add_b"},     {28'b0, add_b},     32'd0);
      chk({tag, " add_cin"},   {31'b0, add_cin},   32'd0);
   endtask

   // Whole-word reference: the effective b and carry-in after the optional subtract.
   function automatic logic [16:0] eff_b_cin(input logic [15:0] bv, input logic ci, input logic sb);
`ifdef FCLA_SEQ_SUB_EN
      if (sb) return {~bv, 1'b1};
`endif
      return {bv, ci};
   endfunction

   // Called just after a negedge, with rst low. Returns at the negedge after the handshake.
   task automatic run_op(input logic [15:0] av, input logic [15:0] bv, input logic ci,
                         input logic sb, input int hold, input logic has_exp,
                         input logic [15:0] exp_sum, input logic exp_cout, input string nm);
      logic [16:0] bc;
      logic [15:0] be;
      logic        ce;
      logic [31:0] full, carry_k, mask;
      logic [15:0] s_hold;
      logic        c_hold;
      int          n, k;
      bit          got;
      bc   = eff_b_cin(bv, ci, sb);
      be   = bc[16:1];
      ce   = bc[0];
      full = {16'b0, av} + {16'b0, be} + {31'b0, ce};
      in_valid  = 1'b1;
      a         = av;
      b         = bv;
      cin       = ci;
      op_sub    = sb;
      out_ready = 1'b0;
      chk({nm, " in_ready before accept"}, {31'b0, in_ready}, 32'd1);
      @(posedge clk);
      n   = 0;
      got = 0;
      while (!got && n < 40) begin
         @(negedge clk);
         if (out_valid) begin
            got = 1;
         end else begin
            if (n < 12) begin
               k       = n / 3;
               mask    = (32'd1 << (4 * k)) - 32'd1;
               carry_k = (({16'b0, av} & mask) + ({16'b0, be} & mask) + {31'b0, ce}) >> (4 * k);
               chk($sformatf("%s add_a n%0d", nm, n), {28'b0, add_a}, {28'b0, av[4*k +: 4]});
               chk($sformatf("%s add_b n%0d", nm, n), {28'b0, add_b}, {28'b0, be[4*k +: 4]});
               chk($sformatf("%s add_cin n%0d", nm, n), {31'b0, add_cin}, {31'b0, carry_k[0]});
            end
            chk($sformatf("%s in_ready busy n%0d", nm, n), {31'b0, in_ready}, 32'd0);
            in_valid = 1'($urandom);
            a        = 16'($urandom);
            b        = 16'($urandom);
            cin      = 1'($urandom);
            op_sub   = 1'($urandom);
            @(posedge clk);
            n++;
         end
      end
      if (!got) begin
         chk({nm, " out_valid timeout"}, 32'd0, 32'd1);
         return;
      end
      chk({nm, " latency"}, n, 32'd12);
      chk({nm, " sum model"},  {16'b0, sum},  {16'b0, full[15:0]});
      chk({nm, " cout model"}, {31'b0, cout}, {31'b0, full[16]});
      if (has_exp) begin
         chk({nm, " sum"},  {16'b0, sum},  {16'b0, exp_sum});
         chk({nm, " cout"}, {31'b0, cout}, {31'b0, exp_cout});
      end
      s_hold = sum;
      c_hold = cout;
      for (int h = 0; h < hold; h++) begin
         @(posedge clk);
         @(negedge clk);
         chk($sformatf("%s hold out_valid %0d", nm, h), {31'b0, out_valid}, 32'd1);
         chk($sformatf("%s hold sum %0d", nm, h), {16'b0, sum}, {16'b0, s_hold});
         chk($sformatf("%s hold cout %0d", nm, h), {31'b0, cout}, {31'b0, c_hold});
         chk($sformatf("%s hold in_ready %0d", nm, h), {31'b0, in_ready}, 32'd0);
         in_valid = 1'($urandom);
      end
      out_ready = 1'b1;
      in_valid  = 1'b1;
      chk({nm, " in_ready at handshake"}, {31'b0, in_ready}, 32'd0);
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      in_valid  = 1'b0;
      chk({nm, " out_valid after hs"}, {31'b0, out_valid}, 32'd0);
      chk({nm, " in_ready after hs"},  {31'b0, in_ready},  32'd1);
   endtask

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic        cin;
      logic        sub;
      int          hold;
      logic [15:0] exp_sum;
      logic        exp_cout;
   } vec_t;

   vec_t vecs[$];

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      a         = '0;
      b         = '0;
      cin       = 1'b0;
      op_sub    = 1'b0;
      out_ready = 1'b0;

      vecs.push_back('{16'h1234, 16'h4321, 1'b0, 1'b0, 0, 16'h5555, 1'b0});
      vecs.push_back('{16'hFFFF, 16'h0001, 1'b0, 1'b0, 0, 16'h0000, 1'b1});
      vecs.push_back('{16'h00FF, 16'h0F01, 1'b1, 1'b0, 5, 16'h1001, 1'b0});
      vecs.push_back('{16'h0000, 16'h0000, 1'b1, 1'b0, 1, 16'h0001, 1'b0});
      vecs.push_back('{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 0, 16'hFFFF, 1'b1});
      vecs.push_back('{16'h8000, 16'h8000, 1'b0, 1'b0, 2, 16'h0000, 1'b1});
`ifdef FCLA_SEQ_SUB_EN
      vecs.push_back('{16'h0005, 16'h0007, 1'b0, 1'b1, 0, 16'hFFFE, 1'b0});
      vecs.push_back('{16'h0007, 16'h0005, 1'b0, 1'b1, 0, 16'h0002, 1'b1});
`else
      vecs.push_back('{16'h0005, 16'h0007, 1'b0, 1'b1, 0, 16'h000C, 1'b0});
`endif

      #2;
      chk_reset_vals("reset no clk");
      @(negedge clk);
      rst = 1'b0;

      foreach (vecs[i])
         run_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, vecs[i].hold,
                1'b1, vecs[i].exp_sum, vecs[i].exp_cout, $sformatf("vec%0d", i));

      for (int r = 0; r < 20; r++)
         run_op(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom),
                int'($urandom_range(0, 3)), 1'b0, 16'h0, 1'b0, $sformatf("rnd%0d", r));

      // Abort during nibble 2 WAIT: accept on E0, nibble 2 issued on E6, so it is in WAIT after E7.
      in_valid  = 1'b1;
      a         = 16'hAAAA;
      b         = 16'h5555;
      cin       = 1'b1;
      op_sub    = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (7) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk_reset_vals("reset mid-op");
      @(negedge clk);
      chk_reset_vals("reset held");
      @(posedge clk);
      @(negedge clk);
      chk_reset_vals("reset held2");
      rst = 1'b0;
      run_op(16'h0001, 16'h0001, 1'b0, 1'b0, 0, 1'b1, 16'h0002, 1'b0, "after reset");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global timeout");
      $fatal(1, "timeout");
   end

endmodule
